mc_ctrl: RTL
============

Name: mc_ctrl

Overview:
- Multi-cycle MIPS-subset main controller. It sits directly upstream of the ALU: it drives the ALU's 3-bit control code and operand-select muxes, and consumes the ALU zero flag to resolve beq.
- Moore FSM over fetch, decode, execute, memory and writeback states, with a memory-ready handshake and a sticky illegal-instruction trap.

Parameters:
- USE_MEM_READY, 1: 1 = IF, LW and SW states wait for i_mem_ready. 0 = i_mem_ready is ignored and treated as 1.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- i_op  in  6  instruction opcode [31:26], held stable by the IR after IF
- i_funct  in  6  instruction funct [5:0]
- i_zf  in  1  ALU zero flag
- i_mem_ready  in  1  memory access complete this cycle
- o_pc_we  out  1  PC write enable
- o_iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- o_mem_read  out  1  memory read request
- o_mem_write  out  1  memory write request
- o_ir_write  out  1  IR load enable
- o_reg_dst  out  1  destination register select: 1 = rd, 0 = rt
- o_mem_to_reg  out  1  writeback source: 1 = MDR, 0 = ALUOut
- o_reg_write  out  1  register file write enable
- o_alu_src_a  out  1  ALU A select: 0 = PC, 1 = A register
- o_alu_src_b  out  2  ALU B select: 00 = B register, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
- o_ext_zero  out  1  immediate extension: 1 = zero-extend
- o_pc_source  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- o_alu_ctrl  out  3  ALU control code
- o_state  out  4  current state, for debug/display
- o_illegal  out  1  sticky illegal-instruction flag

Behaviour:
- ALU control codes: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- State register only is sequential. Outputs are a combinational decode of state, plus i_zf and i_mem_ready where noted.
- Any output not listed for a state is 0.
- Reset: while rst=1, every output is forced to 0 and o_state reads 0. On the clock edge with rst=1, state <= S_IF and the illegal flag is cleared. Reset mid-instruction aborts it; no memory or register write occurs during the reset cycle.
- State encoding: S_IF=0, S_ID=1, S_MA=2, S_LW=3, S_WB_LW=4, S_SW=5, S_EX_R=6, S_WB_R=7, S_BEQ=8, S_J=9, S_EX_I=10, S_WB_I=11, S_ERR=15.
- Per-state outputs and transitions:
  - S_IF: mem_read=1, alu_src_b=01, alu_ctrl=010. ir_write and pc_we = ready. Goes to S_ID when ready, else stays.
  - S_ID: alu_src_b=11, alu_ctrl=010 (branch target into ALUOut). Next state by i_op:
    - 000000 -> S_EX_R if funct is valid, else S_ERR
    - 100011 or 101011 -> S_MA
    - 000100 -> S_BEQ
    - 000010 -> S_J
    - anything else -> S_ERR
  - S_MA: src_a=1, src_b=10, alu_ctrl=010. Goes to S_LW (lw) or S_SW (sw).
  - S_LW: mem_read=1, iord=1. Goes to S_WB_LW when ready.
  - S_WB_LW: reg_write=1, mem_to_reg=1, reg_dst=0. Goes to S_IF.
  - S_SW: mem_write=1, iord=1. Goes to S_IF when ready. mem_write stays high while stalled.
  - S_EX_R: src_a=1, src_b=00. alu_ctrl from funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111. Goes to S_WB_R.
  - S_WB_R: reg_write=1, reg_dst=1. Goes to S_IF.
  - S_BEQ: src_a=1, src_b=00, alu_ctrl=110, pc_source=01, pc_we=i_zf. Goes to S_IF.
  - S_J: pc_source=10, pc_we=1. Goes to S_IF.
  - S_ERR: all controls 0, o_illegal=1. Holds until rst.
- Instruction latency excluding stalls: R 4, lw 5, sw 4, beq 3, j 3 cycles. Each cycle with i_mem_ready=0 in IF, LW or SW adds one cycle.
- The unused state codes 12-14 go to S_ERR.

Optional Feature:
- IMM_OPS_EN defined: S_ID also decodes addi 001000, andi 001100, ori 001101 and slti 001010 to S_EX_I.
  - S_EX_I: src_a=1, src_b=10. alu_ctrl = 010/000/001/111 respectively. ext_zero=1 for andi and ori only.
  - S_WB_I: reg_write=1, reg_dst=0, mem_to_reg=0.
- IMM_OPS_EN undefined: those opcodes go to S_ERR, and S_EX_I / S_WB_I are unreachable.

Decomposition:
- Package mc_pkg holds: state encodings, opcode and funct constants, ALU control code constants, ALU-B select constants.
- One sub-module, alu_ctrl_dec: combinational funct (and opcode under IMM_OPS_EN) -> alu_ctrl[2:0] plus a valid flag. It is used by both S_ID validity checking and execute-state decode.

Test Plan:
- add (op 000000, funct 100000), ready=1: o_state sequence 0,1,6,7,0. alu_ctrl=010 in S_EX_R. reg_write=1 and reg_dst=1 only in S_WB_R.
- lw with ready held 0 for 3 cycles in S_LW: S_LW lasts 4 cycles with mem_read=1 and iord=1 throughout, then S_WB_LW with mem_to_reg=1. Total 8 cycles.
- beq with i_zf=1 then i_zf=0: in S_BEQ alu_ctrl=110 and pc_source=01. pc_we=1 in the first case, 0 in the second. 3 cycles each.
- Opcode 111111: S_IF -> S_ID -> S_ERR. o_illegal=1 and stays 1 over 20 cycles. rst=1 for one cycle clears it; next state is S_IF with o_illegal=0.
- R-type with funct 000111: goes to S_ERR. Separately, assert rst in S_SW: mem_write=0 in the reset cycle, and the next cycle is S_IF.
- With IMM_OPS_EN, ori (001101): S_EX_I with alu_ctrl=001, ext_zero=1, src_b=10, then S_WB_I with reg_write=1. Without the macro, the same opcode goes to S_ERR.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared constants and the control-word type for the multi-cycle MIPS-subset controller.
package mc_pkg;

  localparam logic [3:0] S_IF    = 4'd0;
  localparam logic [3:0] S_ID    = 4'd1;
  localparam logic [3:0] S_MA    = 4'd2;
  localparam logic [3:0] S_LW    = 4'd3;
  localparam logic [3:0] S_WB_LW = 4'd4;
  localparam logic [3:0] S_SW    = 4'd5;
  localparam logic [3:0] S_EX_R  = 4'd6;
  localparam logic [3:0] S_WB_R  = 4'd7;
  localparam logic [3:0] S_BEQ   = 4'd8;
  localparam logic [3:0] S_J     = 4'd9;
  localparam logic [3:0] S_EX_I  = 4'd10;
  localparam logic [3:0] S_WB_I  = 4'd11;
  localparam logic [3:0] S_ERR   = 4'd15;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_we;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [1:0] pc_source;
    logic [2:0] alu_ctrl;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_alu_ctrl_dec.sv
// funct (and opcode when IMM_OPS_EN is defined) to ALU control code, with a valid flag.
module alu_ctrl_dec
  import mc_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_ctrl,
  output logic       o_valid,
  output logic       o_ext_zero
);

  always_comb begin
    o_alu_ctrl = ALU_ADD;
    o_valid    = 1'b0;
    o_ext_zero = 1'b0;
    if (i_op == OP_RTYPE) begin
      o_valid = 1'b1;
      case (i_funct)
        FN_ADD:  o_alu_ctrl = ALU_ADD;
        FN_SUB:  o_alu_ctrl = ALU_SUB;
        FN_AND:  o_alu_ctrl = ALU_AND;
        FN_OR:   o_alu_ctrl = ALU_OR;
        FN_SLT:  o_alu_ctrl = ALU_SLT;
        default: o_valid    = 1'b0;
      endcase
    end
`ifdef IMM_OPS_EN
    else begin
      o_valid = 1'b1;
      case (i_op)
        OP_ADDI: o_alu_ctrl = ALU_ADD;
        OP_ANDI: begin o_alu_ctrl = ALU_AND; o_ext_zero = 1'b1; end
        OP_ORI:  begin o_alu_ctrl = ALU_OR;  o_ext_zero = 1'b1; end
        OP_SLTI: o_alu_ctrl = ALU_SLT;
        default: o_valid = 1'b0;
      endcase
    end
`endif
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset main controller: Moore FSM with memory-ready stalls and an illegal trap.
// Define IMM_OPS_EN to add addi/andi/ori/slti decode through S_EX_I / S_WB_I.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  input  logic       i_zf,
  input  logic       i_mem_ready,
  output logic       o_pc_we,
  output logic       o_iord,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_ir_write,
  output logic       o_reg_dst,
  output logic       o_mem_to_reg,
  output logic       o_reg_write,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic       o_ext_zero,
  output logic [1:0] o_pc_source,
  output logic [2:0] o_alu_ctrl,
  output logic [3:0] o_state,
  output logic       o_illegal
);

  logic [3:0] state_q, state_d;
  ctrl_t      ctrl;
  logic       mem_rdy;
  logic [2:0] dec_alu_ctrl;
  logic       dec_valid;
  logic       dec_ext_zero;

  assign mem_rdy = USE_MEM_READY ? i_mem_ready : 1'b1;

  alu_ctrl_dec u_dec (
    .i_op       (i_op),
    .i_funct    (i_funct),
    .o_alu_ctrl (dec_alu_ctrl),
    .o_valid    (dec_valid),
    .o_ext_zero (dec_ext_zero)
  );

  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    case (state_q)
      S_IF: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_ctrl  = ALU_ADD;
        ctrl.ir_write  = mem_rdy;
        ctrl.pc_we     = mem_rdy;
        state_d        = mem_rdy ? S_ID : S_IF;
      end
      S_ID: begin
        // Branch target is computed speculatively into ALUOut during decode.
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_ctrl  = ALU_ADD;
        case (i_op)
          OP_RTYPE:     state_d = dec_valid ? S_EX_R : S_ERR;
          OP_LW, OP_SW: state_d = S_MA;
          OP_BEQ:       state_d = S_BEQ;
          OP_J:         state_d = S_J;
`ifdef IMM_OPS_EN
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = dec_valid ? S_EX_I : S_ERR;
`endif
          default:      state_d = S_ERR;
        endcase
      end
      S_MA: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_ctrl  = ALU_ADD;
        state_d        = (i_op == OP_SW) ? S_SW : S_LW;
      end
      S_LW: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        state_d       = mem_rdy ? S_WB_LW : S_LW;
      end
      S_WB_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        state_d         = S_IF;
      end
      S_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        state_d        = mem_rdy ? S_IF : S_SW;
      end
      S_EX_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_ctrl  = dec_alu_ctrl;
        state_d        = S_WB_R;
      end
      S_WB_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        state_d        = S_IF;
      end
      S_BEQ: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_ctrl  = ALU_SUB;
        ctrl.pc_source = PCSRC_ALUOUT;
        ctrl.pc_we     = i_zf;
        state_d        = S_IF;
      end
      S_J: begin
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.pc_we     = 1'b1;
        state_d        = S_IF;
      end
`ifdef IMM_OPS_EN
      S_EX_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_ctrl  = dec_alu_ctrl;
        ctrl.ext_zero  = dec_ext_zero;
        state_d        = S_WB_I;
      end
      S_WB_I: begin
        ctrl.reg_write = 1'b1;
        state_d        = S_IF;
      end
`endif
      S_ERR: begin
        ctrl.illegal = 1'b1;
        state_d      = S_ERR;
      end
      default: state_d = S_ERR;
    endcase
    // Reset masks every output so an aborted instruction cannot write anything.
    if (rst) ctrl = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IF;
    else     state_q <= state_d;
  end

  assign o_pc_we      = ctrl.pc_we;
  assign o_iord       = ctrl.iord;
  assign o_mem_read   = ctrl.mem_read;
  assign o_mem_write  = ctrl.mem_write;
  assign o_ir_write   = ctrl.ir_write;
  assign o_reg_dst    = ctrl.reg_dst;
  assign o_mem_to_reg = ctrl.mem_to_reg;
  assign o_reg_write  = ctrl.reg_write;
  assign o_alu_src_a  = ctrl.alu_src_a;
  assign o_alu_src_b  = ctrl.alu_src_b;
  assign o_ext_zero   = ctrl.ext_zero;
  assign o_pc_source  = ctrl.pc_source;
  assign o_alu_ctrl   = ctrl.alu_ctrl;
  assign o_illegal    = ctrl.illegal;
  assign o_state      = rst ? 4'd0 : state_q;

endmodule
